// File: rtl/aesl_deadlock_pkg.sv
// Shared types and constants for the co-simulation deadlock-monitoring harness.
// Contents:
//   ch_state_e            per-channel stall FSM state (IDLE / WAIT / BLOCKED)
//   DEFAULT_STALL_THRESH  default consecutive-stall threshold used by monitors
//   STATS_W               width of the optional per-channel stall statistics
package aesl_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        BLOCKED = 2'd2
    } ch_state_e;

    localparam int DEFAULT_STALL_THRESH = 16;
    localparam int STATS_W              = 32;

endpackage

// File: rtl/aesl_axis_stall_channel.sv
// One AXIS channel stall tracker: FSM plus consecutive-stall counter.
// Optional macro AXIS_BLOCK_STATS_EN adds a saturating lifetime stall counter.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              monitoring active; low forces IDLE with counter 0
//   stall               req & ~ack for this channel
//   blocked             registered: channel is in BLOCKED
//   blocked_nx          combinational next value of blocked (for the
//                       top's same-cycle any/event registers)
//   total_stall_cycles  (AXIS_BLOCK_STATS_EN only) enabled stall cycles
//                       since reset, saturating
module aesl_axis_stall_channel
    import aesl_deadlock_pkg::*;
#(
    parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
    parameter int CNT_W        = $clog2(STALL_THRESH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               stall,
`ifdef AXIS_BLOCK_STATS_EN
    output logic [STATS_W-1:0] total_stall_cycles,
`endif
    output logic               blocked,
    output logic               blocked_nx
);

    localparam logic [CNT_W-1:0] THR    = CNT_W'(STALL_THRESH);
    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(STALL_THRESH - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    ch_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            blocked <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            blocked <= blocked_nx;
        end
    end

    // Any non-stall cycle (or monitoring disabled) drops straight back to
    // IDLE, so only an unbroken run of stalls can reach BLOCKED.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!enable || !stall) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nx   = ONE;
                    state_nx = (STALL_THRESH == 1) ? BLOCKED : WAIT;
                end
                WAIT: begin
                    if (cnt == THR_M1) begin
                        state_nx = BLOCKED;
                        cnt_nx   = THR;
                    end else begin
                        cnt_nx   = cnt + ONE;
                    end
                end
                BLOCKED: begin
                    state_nx = BLOCKED;
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
        blocked_nx = (state_nx == BLOCKED);
    end

`ifdef AXIS_BLOCK_STATS_EN
    // Lifetime counter: survives enable drops, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset)
            total_stall_cycles <= '0;
        else if (enable && stall && (total_stall_cycles != {STATS_W{1'b1}}))
            total_stall_cycles <= total_stall_cycles + 1'b1;
    end
`endif

endmodule

// File: rtl/aesl_axis_block_detector.sv
// AXI-Stream stall detector feeding the per-instance deadlock monitor.
// A channel is reported blocked only after STALL_THRESH consecutive stall
// cycles (req without ack), so normal back-pressure is not flagged.
// Optional macro AXIS_BLOCK_STATS_EN adds per-channel stall statistics with a
// registered read port.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   enable           monitoring active (DUT start..done)
//   ch_req, ch_ack   per-channel transfer request / completion
//   axis_block_sigs  registered per-channel blocked flags
//   block_any        registered OR of axis_block_sigs
//   block_event      one-cycle pulse when blocked set goes from empty to non-empty
//   first_block_ch   lowest newly-blocked channel at the latest block_event
//   stats_sel        (AXIS_BLOCK_STATS_EN) channel to read
//   stats_count      (AXIS_BLOCK_STATS_EN) registered stall total, 1-cycle latency
module aesl_axis_block_detector
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
    parameter int CNT_W        = $clog2(STALL_THRESH + 1),
    localparam int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_CH-1:0]  ch_req,
    input  logic [NUM_CH-1:0]  ch_ack,
`ifdef AXIS_BLOCK_STATS_EN
    input  logic [IDX_W-1:0]   stats_sel,
    output logic [STATS_W-1:0] stats_count,
`endif
    output logic [NUM_CH-1:0]  axis_block_sigs,
    output logic               block_any,
    output logic               block_event,
    output logic [IDX_W-1:0]   first_block_ch
);

    logic [NUM_CH-1:0] stall;
    logic [NUM_CH-1:0] blk_nx;
    logic [IDX_W-1:0]  low_idx;
    logic              new_event;
`ifdef AXIS_BLOCK_STATS_EN
    logic [NUM_CH-1:0][STATS_W-1:0] totals;
`endif

    assign stall = ch_req & ~ch_ack;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        aesl_axis_stall_channel #(
            .STALL_THRESH (STALL_THRESH),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clock              (clock),
            .reset              (reset),
            .enable             (enable),
            .stall              (stall[g]),
`ifdef AXIS_BLOCK_STATS_EN
            .total_stall_cycles (totals[g]),
`endif
            .blocked            (axis_block_sigs[g]),
            .blocked_nx         (blk_nx[g])
        );
    end

    // Lowest set bit of the next blocked vector; only consulted when nothing
    // was blocked before, so every set bit is a newly blocked channel.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (blk_nx[i]) low_idx = IDX_W'(i);
    end

    assign new_event = enable && (|blk_nx) && !(|axis_block_sigs);

    always_ff @(posedge clock) begin
        if (reset) begin
            block_any      <= 1'b0;
            block_event    <= 1'b0;
            first_block_ch <= '0;
        end else begin
            block_any   <= |blk_nx;
            block_event <= new_event;
            if (new_event)
                first_block_ch <= low_idx;
        end
    end

`ifdef AXIS_BLOCK_STATS_EN
    always_ff @(posedge clock) begin
        if (reset)
            stats_count <= '0;
        else if (32'(stats_sel) < NUM_CH)
            stats_count <= totals[stats_sel];
        else
            stats_count <= '0;
    end
`endif

endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Randomized + directed scoreboard bench for aesl_axis_block_detector
// (NUM_CH=4, STALL_THRESH=4). The reference model tracks the length of each
// channel's current unbroken stall run; a channel is blocked when the run
// reaches the threshold.
module tb_aesl_axis_block_detector;

    localparam int NCH = 4;
    localparam int THR = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [NCH-1:0] ch_req = '0;
    logic [NCH-1:0] ch_ack = '0;
    logic [1:0]     stats_sel = '0;
    logic [NCH-1:0] axis_block_sigs;
    logic           block_any;
    logic           block_event;
    logic [1:0]     first_block_ch;
`ifdef AXIS_BLOCK_STATS_EN
    logic [31:0]    stats_count;
`endif

    always #5 clock = ~clock;

    aesl_axis_block_detector #(
        .NUM_CH       (NCH),
        .STALL_THRESH (THR)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .ch_req          (ch_req),
        .ch_ack          (ch_ack),
`ifdef AXIS_BLOCK_STATS_EN
        .stats_sel       (stats_sel),
        .stats_count     (stats_count),
`endif
        .axis_block_sigs (axis_block_sigs),
        .block_any       (block_any),
        .block_event     (block_event),
        .first_block_ch  (first_block_ch)
    );

    typedef struct {
        logic [NCH-1:0] sigs;
        logic           any;
        logic           evt;
        logic [1:0]     first;
        logic [31:0]    stats;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    int          run [NCH];
    logic [31:0] tot [NCH];
    logic        m_any = 1'b0;
    logic [1:0]  m_first = '0;
    logic [31:0] m_stats = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs and push the outputs expected after the edge.
    task automatic step(input logic r, input logic e, input logic [NCH-1:0] rq,
                        input logic [NCH-1:0] ak, input logic [1:0] sl);
        exp_t x;
        logic [NCH-1:0] blk;
        logic prev_any;
        @(negedge clock);
        reset = r; enable = e; ch_req = rq; ch_ack = ak; stats_sel = sl;
        prev_any = m_any;
        blk = '0;
        if (r) begin
            for (int i = 0; i < NCH; i++) begin run[i] = 0; tot[i] = 0; end
            m_any = 0; m_first = 0; m_stats = 0;
            x.evt = 0;
        end else begin
            m_stats = tot[sl];
            for (int i = 0; i < NCH; i++) begin
                if (e && rq[i] && !ak[i]) begin
                    run[i] = (run[i] < THR) ? run[i] + 1 : THR;
                    if (tot[i] != 32'hFFFF_FFFF) tot[i] = tot[i] + 1;
                end else begin
                    run[i] = 0;
                end
                blk[i] = (run[i] >= THR);
            end
            m_any = |blk;
            x.evt = m_any && !prev_any;
            if (x.evt) begin
                for (int i = NCH - 1; i >= 0; i--)
                    if (blk[i]) m_first = 2'(i);
            end
        end
        x.sigs = blk; x.any = m_any; x.first = m_first; x.stats = m_stats;
        q.push_back(x);
    endtask

    // Monitor: checks the outputs presented after every edge.
    always @(posedge clock) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("axis_block_sigs", 32'(axis_block_sigs), 32'(x.sigs));
            chk("block_any",       32'(block_any),       32'(x.any));
            chk("block_event",     32'(block_event),     32'(x.evt));
            chk("first_block_ch",  32'(first_block_ch),  32'(x.first));
`ifdef AXIS_BLOCK_STATS_EN
            chk("stats_count",     stats_count,          x.stats);
`endif
        end
    end

    initial begin
        int drain;
        for (int i = 0; i < NCH; i++) begin run[i] = 0; tot[i] = 0; end

        repeat (3) step(1, 0, '0, '0, 0);
        // idle, enabled
        repeat (20) step(0, 1, '0, '0, 0);
        // ch0 short stall then ack: never blocks
        repeat (3) step(0, 1, 4'b0001, 4'b0000, 0);
        step(0, 1, 4'b0001, 4'b0001, 0);
        repeat (2) step(0, 1, '0, '0, 0);
        // ch2 held stall -> blocks on 4th edge, then ack clears
        repeat (6) step(0, 1, 4'b0100, 4'b0000, 0);
        step(0, 1, 4'b0100, 4'b0100, 0);
        repeat (2) step(0, 1, '0, '0, 0);
        // ch1 and ch3 together
        repeat (5) step(0, 1, 4'b1010, 4'b0000, 0);
        step(0, 1, 4'b0000, 4'b0000, 0);
        // ch0 blocked, enable drop one cycle, then full restart
        repeat (5) step(0, 1, 4'b0001, 4'b0000, 0);
        step(0, 0, 4'b0001, 4'b0000, 0);
        repeat (5) step(0, 1, 4'b0001, 4'b0000, 0);
        step(0, 1, 4'b0000, 4'b0000, 0);
        // ch3 stalls interleaved with acks, then read stats
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 4'b1000, 4'b0000, 3);
            step(0, 1, 4'b1000, 4'b1000, 3);
        end
        repeat (3) step(0, 1, '0, '0, 3);
        // ack without req is non-stall
        repeat (6) step(0, 1, 4'b0000, 4'b1111, 2);
        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            logic [NCH-1:0] rq, ak;
            for (int i = 0; i < NCH; i++) begin
                rq[i] = ($urandom_range(3) != 0);
                ak[i] = ($urandom_range(5) == 0);
            end
            step(($urandom_range(299) == 0), ($urandom_range(49) != 0),
                 rq, ak, 2'($urandom_range(3)));
        end
        repeat (3) step(0, 1, '0, '0, 0);

        drain = 0;
        while (q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #2;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
